// File: rtl/m_lsu_ctrl.sv
// m_lsu_ctrl: memory-stage load/store unit for the pipelined MIPS core.
// Decodes lw/lh/lhu/lb/lbu/sw/sh/sb, checks alignment, runs a req/ack data bus
// with byte enables and returns lane-selected, extended load data.
// Optional feature macro: LSU_TIMEOUT_EN (bus watchdog raising DBE, code 7).
module m_lsu_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [31:0]         instr,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wdata,
  input  logic [31:0]         pc,
  input  logic                flush,
  output logic                stall,
  output logic                resp_valid,
  output logic [31:0]         rdata,
  output logic                exc_valid,
  output logic [4:0]          exc_code,
  output logic [ADDR_W-1:0]   exc_badva,
  output logic [31:0]         exc_pc,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // size: 0 byte, 1 half, 2 word
  typedef struct packed {
    logic       mem;
    logic       store;
    logic       sgn;
    logic [1:0] size;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op);
    dec_t d;
    d = '0;
    case (op)
      6'b100000: d = '{1'b1, 1'b0, 1'b1, 2'd0}; // lb
      6'b100100: d = '{1'b1, 1'b0, 1'b0, 2'd0}; // lbu
      6'b100001: d = '{1'b1, 1'b0, 1'b1, 2'd1}; // lh
      6'b100101: d = '{1'b1, 1'b0, 1'b0, 2'd1}; // lhu
      6'b100011: d = '{1'b1, 1'b0, 1'b0, 2'd2}; // lw
      6'b101000: d = '{1'b1, 1'b1, 1'b0, 2'd0}; // sb
      6'b101001: d = '{1'b1, 1'b1, 1'b0, 2'd1}; // sh
      6'b101011: d = '{1'b1, 1'b1, 1'b0, 2'd2}; // sw
      default:   d = '0;
    endcase
    return d;
  endfunction

  state_t              state_q, state_d;
  logic [5:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         pc_q, pc_d;
  logic                kill_q, kill_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                exc_q, exc_d;
  logic [4:0]          code_q, code_d;
`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

  dec_t                dec_in, dec_q;
  logic                misaligned;
  logic [OFF_W-1:0]    off;
  logic [31:0]         sel;
  logic [31:0]         load_ext;
  logic [NB-1:0]       be_base;
  logic                unused_bits;

  assign dec_in     = decode(instr[31:26]);
  assign dec_q      = decode(op_q);
  assign misaligned = ((dec_in.size == 2'd2) && (addr[1:0] != 2'b00)) ||
                      ((dec_in.size == 2'd1) && addr[0]);
  assign off        = addr_q[OFF_W-1:0];
  assign sel        = 32'(mem_rdata >> {off, 3'b000});

`ifdef LSU_TIMEOUT_EN
  assign unused_bits = ^{instr[25:0], dec_q.mem, dec_in.sgn};
`else
  assign unused_bits = ^{instr[25:0], dec_q.mem, dec_in.sgn, (TIMEOUT > 0)};
`endif

  // Pick the addressed lane and sign/zero-extend it to 32 bits
  always_comb begin
    case (dec_q.size)
      2'd0:    load_ext = {{24{dec_q.sgn & sel[7]}}, sel[7:0]};
      2'd1:    load_ext = {{16{dec_q.sgn & sel[15]}}, sel[15:0]};
      default: load_ext = sel;
    endcase
  end

  // Bus drive: everything held from latched request, zero when idle
  always_comb begin
    case (dec_q.size)
      2'd0:    be_base = NB'(4'h1);
      2'd1:    be_base = NB'(4'h3);
      default: be_base = NB'(4'hF);
    endcase
    mem_req   = (state_q == S_BUS);
    mem_we    = mem_req & dec_q.store;
    mem_be    = mem_req ? NB'(be_base << off) : '0;
    mem_addr  = mem_req ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
    mem_wdata = '0;
    if (mem_req && dec_q.store) begin
      case (dec_q.size)
        2'd0:    mem_wdata = {NB{wdata_q[7:0]}};
        2'd1:    mem_wdata = {(NB/2){wdata_q[15:0]}};
        default: mem_wdata = {(NB/4){wdata_q}};
      endcase
    end
  end

  // Next-state logic for IDLE -> (BUS) -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    code_d  = code_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // a flush in the same cycle kills the request before acceptance
        if (req_valid && !flush) begin
          op_d    = instr[31:26];
          addr_d  = addr;
          wdata_d = wdata;
          pc_d    = pc;
          kill_d  = 1'b0;
          rdata_d = '0;
          exc_d   = 1'b0;
          code_d  = '0;
`ifdef LSU_TIMEOUT_EN
          cnt_d   = '0;
`endif
          if (!dec_in.mem) begin
            state_d = S_RESP;
          end else if (misaligned) begin
            exc_d   = 1'b1;
            code_d  = dec_in.store ? 5'd5 : 5'd4;
            state_d = S_RESP;
          end else begin
            state_d = S_BUS;
          end
        end
      end
      S_BUS: begin
        // the bus transfer must complete; a flush only marks it dead
        if (flush) kill_d = 1'b1;
        if (mem_ack) begin
          rdata_d = dec_q.store ? 32'd0 : load_ext;
          state_d = S_RESP;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          exc_d   = 1'b1;
          code_d  = 5'd7;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and request registers, asynchronously cleared
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      pc_q    <= '0;
      kill_q  <= 1'b0;
      rdata_q <= '0;
      exc_q   <= 1'b0;
      code_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
      code_q  <= code_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign stall      = (state_q == S_BUS);
  assign resp_valid = (state_q == S_RESP) && !kill_q && !flush;
  assign exc_valid  = resp_valid && exc_q;
  assign rdata      = (resp_valid && !exc_q) ? rdata_q : '0;
  assign exc_code   = exc_valid ? code_q : '0;
  assign exc_badva  = exc_valid ? addr_q : '0;
  assign exc_pc     = exc_valid ? pc_q : '0;
endmodule
